universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/usr_pkg.sv | 18 +
 rtl/universal_shift_reg_sat_counter.sv | 29 ++
 rtl/universal_shift_reg.sv | 91 +++++++++
 tb/tb_universal_shift_reg.sv | 112 +++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// for the DUT, its parents and its benches.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    localparam int unsigned MODE_W = 3;

endpackage

// File: rtl/universal_shift_reg_sat_counter.sv
// Saturating up-counter: counts serial bits accepted, parks at MAX, and can be
// forced straight to MAX (parallel load) or cleared.
module sat_counter #(
    parameter int MAX = 8
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       load_max,
    input  logic                       inc,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       at_max
);

    localparam int CW = $clog2(MAX + 1);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (load_max) begin
            count <= CW'(MAX);
        end else if (inc && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

    // Pure decode of the registered count, so full tracks fill_cnt with no lag.
    assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates and
// parallel load, with a registered serial-out bit and a saturating fill count.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         sin_lsb,
    input  logic                         sin_msb,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   fill_cnt,
    output logic                         full
);

    mode_e            op;
    logic [WIDTH-1:0] q_next;
    logic             sout_next;
    logic             inc;
    logic             load_max;

    assign op = mode_e'(mode);

    always_comb begin
        q_next    = q;
        sout_next = sout;
        inc       = 1'b0;
        load_max  = 1'b0;
        if (en) begin
            case (op)
                MODE_SHL: begin
                    q_next    = {q[WIDTH-2:0], sin_lsb};
                    sout_next = q[WIDTH-1];
                    inc       = 1'b1;
                end
                MODE_SHR: begin
                    q_next    = {sin_msb, q[WIDTH-1:1]};
                    sout_next = q[0];
                    inc       = 1'b1;
                end
                MODE_ASR: begin
                    q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
                    sout_next = q[0];
                    inc       = 1'b1;
                end
                MODE_ROL: begin
                    q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_next = q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_next    = {q[0], q[WIDTH-1:1]};
                    sout_next = q[0];
                end
                MODE_LOAD: begin
                    q_next   = d;
                    load_max = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VAL;
            sout <= 1'b0;
        end else begin
            q    <= q_next;
            sout <= sout_next;
        end
    end

    // Reset rides on clr so a shift or load sampled with rst is fully discarded.
    sat_counter #(
        .MAX (WIDTH)
    ) u_fill (
        .clk      (clk),
        .clr      (rst),
        .load_max (load_max),
        .inc      (inc),
        .count    (fill_cnt),
        .at_max   (full)
    );

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=4, with a second instance
// using a non-zero reset value sharing the same stimulus.
module tb_universal_shift_reg;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, sin_lsb, sin_msb;
    logic [2:0] mode;
    logic [3:0] d;

    logic [3:0] q_a, q_b;
    logic       sout_a, sout_b, full_a, full_b;
    logic [2:0] fill_a, fill_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(4), .RST_VAL(4'b0000)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb),
        .sin_msb(sin_msb), .d(d), .q(q_a), .sout(sout_a),
        .fill_cnt(fill_a), .full(full_a)
    );

    universal_shift_reg #(.WIDTH(4), .RST_VAL(4'b1010)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb),
        .sin_msb(sin_msb), .d(d), .q(q_b), .sout(sout_b),
        .fill_cnt(fill_b), .full(full_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eq, input logic es,
                         input logic [2:0] ef, input logic efull);
        check({tag, ".q"},    32'(q_a),    32'(eq));
        check({tag, ".sout"}, 32'(sout_a), 32'(es));
        check({tag, ".fill"}, 32'(fill_a), 32'(ef));
        check({tag, ".full"}, 32'(full_a), 32'(efull));
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic sl, input logic sm, input logic [3:0] dd);
        rst = r; en = e; mode = m; sin_lsb = sl; sin_msb = sm; d = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = MODE_LOAD; sin_lsb = 1'b0; sin_msb = 1'b0; d = 4'b1111;

        // Reset held 5 cycles while requesting a LOAD of 1111
        for (int i = 0; i < 5; i++) step(1, 1, MODE_LOAD, 0, 0, 4'b1111);
        chk_a("reset", 4'b0000, 0, 3'd0, 0);
        check("reset_b.q", 32'(q_b), 32'hA);
        check("reset_b.fill", 32'(fill_b), 32'd0);

        // Serial fill via SHR
        step(0, 1, MODE_SHR, 0, 1, 4'b0000); chk_a("shr1", 4'b1000, 0, 3'd1, 0);
        step(0, 1, MODE_SHR, 0, 0, 4'b0000); chk_a("shr2", 4'b0100, 0, 3'd2, 0);
        step(0, 1, MODE_SHR, 0, 1, 4'b0000); chk_a("shr3", 4'b1010, 0, 3'd3, 0);
        step(0, 1, MODE_SHR, 0, 0, 4'b0000); chk_a("shr4", 4'b0101, 0, 3'd4, 1);
        step(0, 1, MODE_SHR, 0, 0, 4'b0000); chk_a("shr5", 4'b0010, 1, 3'd4, 1);

        // Load then rotate; sout untouched by LOAD
        step(0, 1, MODE_LOAD, 0, 0, 4'b1001); chk_a("load1001", 4'b1001, 1, 3'd4, 1);
        step(0, 1, MODE_ROL,  0, 0, 4'b0000); chk_a("rol",      4'b0011, 1, 3'd4, 1);
        step(0, 1, MODE_ROR,  0, 0, 4'b0000); chk_a("ror",      4'b1001, 1, 3'd4, 1);

        // ASR ignores sin_msb; SHL
        step(0, 1, MODE_LOAD, 0, 0, 4'b1000); chk_a("load1000", 4'b1000, 1, 3'd4, 1);
        step(0, 1, MODE_ASR,  0, 0, 4'b0000); chk_a("asr",      4'b1100, 0, 3'd4, 1);
        step(0, 1, MODE_SHL,  1, 0, 4'b0000); chk_a("shl",      4'b1001, 1, 3'd4, 1);

        // Enable low with SHL, then reserved mode: everything holds
        for (int i = 0; i < 3; i++) begin
            step(0, 0, MODE_SHL, 0, 1, 4'b0110); chk_a("en0", 4'b1001, 1, 3'd4, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, MODE_RSVD, 0, 1, 4'b0110); chk_a("rsvd", 4'b1001, 1, 3'd4, 1);
        end

        // Reset during a LOAD discards the load
        step(1, 1, MODE_LOAD, 0, 0, 4'b1111); chk_a("rst_load", 4'b0000, 0, 3'd0, 0);
        check("rst_load_b.q", 32'(q_b), 32'hA);

        // Two SHL shifts, then reset together with SHL
        step(0, 1, MODE_SHL, 1, 0, 4'b0000); chk_a("pre_shl1", 4'b0001, 0, 3'd1, 0);
        check("pre_shl1_b.q", 32'(q_b), 32'h5);
        step(0, 1, MODE_SHL, 1, 0, 4'b0000); chk_a("pre_shl2", 4'b0011, 0, 3'd2, 0);
        check("pre_shl2_b.q", 32'(q_b), 32'hB);
        step(1, 1, MODE_SHL, 1, 0, 4'b0000); chk_a("rst_shl", 4'b0000, 0, 3'd0, 0);
        check("rst_shl_b.q", 32'(q_b), 32'hA);
        check("rst_shl_b.sout", 32'(sout_b), 32'd0);

        // First operation after reset acts on RST_VAL
        step(0, 1, MODE_ROL, 0, 0, 4'b0000); chk_a("post_rol", 4'b0000, 0, 3'd0, 0);
        check("post_rol_b.q", 32'(q_b), 32'h5);
        check("post_rol_b.sout", 32'(sout_b), 32'd1);
        check("post_rol_b.full", 32'(full_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
